// File: rtl/tone_synth.sv
// Polyphonic square-wave tone generator: NUM_VOICES key-tuned voices mixed
// into a single PWM speaker bit.
module tone_synth #(
    parameter int NUM_VOICES = 4,
    parameter int VID_W      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic [VID_W-1:0]      key_voice,
    input  logic                  key_on,
    input  logic [3:0]            key_note,
    input  logic [2:0]            key_octave,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic [NUM_VOICES-1:0] voice_out,
    output logic [VID_W:0]        mix,
    output logic                  speaker
);

    localparam logic [VID_W-1:0] PWM_LAST = VID_W'(NUM_VOICES - 1);

    function automatic logic [19:0] base_half(input logic [3:0] note);
        logic [19:0] t;
        case (note)
            4'd0:    t = 20'd47778;
            4'd1:    t = 20'd45097;
            4'd2:    t = 20'd42566;
            4'd3:    t = 20'd40177;
            4'd4:    t = 20'd37922;
            4'd5:    t = 20'd35793;
            4'd6:    t = 20'd33784;
            4'd7:    t = 20'd31888;
            4'd8:    t = 20'd30098;
            4'd9:    t = 20'd28409;
            4'd10:   t = 20'd26815;
            4'd11:   t = 20'd25310;
            default: t = 20'd0;
        endcase
        return t;
    endfunction

    // Octave 4 is the reference; lower octaves double per step, higher ones halve (truncating).
    function automatic logic [19:0] scaled_half(input logic [3:0] note, input logic [2:0] oct);
        logic [19:0] t;
        t = base_half(note);
        if (oct < 3'd4) begin
            return t << (3'd4 - oct);
        end else begin
            return t >> (oct - 3'd4);
        end
    endfunction

    function automatic logic [VID_W:0] popcount(input logic [NUM_VOICES-1:0] bits);
        logic [VID_W:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            acc = acc + {{VID_W{1'b0}}, bits[i]};
        end
        return acc;
    endfunction

    logic                  key_ready_q;
    logic [NUM_VOICES-1:0] active_q, active_d;
    logic [NUM_VOICES-1:0] vout_q, vout_d;
    logic [19:0]           half_q [NUM_VOICES];
    logic [19:0]           half_d [NUM_VOICES];
    logic [19:0]           cnt_q  [NUM_VOICES];
    logic [19:0]           cnt_d  [NUM_VOICES];
    logic [VID_W:0]        mix_q, mix_d;
    logic [VID_W-1:0]      pwm_q, pwm_d;
    logic                  spk_q, spk_d;
    logic                  cmd_fire_s;
    logic                  note_ok_s;
    logic [19:0]           cmd_half_s;

    // Voice next-state: an addressed command overrides free-running counting.
    always_comb begin
        cmd_fire_s = key_valid & key_ready_q;
        note_ok_s  = (key_note < 4'd12);
        cmd_half_s = scaled_half(key_note, key_octave);
        active_d   = active_q;
        vout_d     = vout_q;
        half_d     = half_q;
        cnt_d      = cnt_q;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (cmd_fire_s && (key_voice == VID_W'(v))) begin
                if (key_on && note_ok_s) begin
                    half_d[v]   = cmd_half_s;
                    active_d[v] = 1'b1;
                end else begin
                    active_d[v] = 1'b0;
                end
                cnt_d[v]  = 20'd0;
                vout_d[v] = 1'b0;
            end else if (active_q[v]) begin
                if (cnt_q[v] == half_q[v] - 20'd1) begin
                    cnt_d[v]  = 20'd0;
                    vout_d[v] = ~vout_q[v];
                end else begin
                    cnt_d[v]  = cnt_q[v] + 20'd1;
                end
            end else begin
                cnt_d[v]  = 20'd0;
                vout_d[v] = 1'b0;
            end
        end
    end

    // Mixer and PWM: mix lags voice_out by one cycle, speaker lags mix by one.
    always_comb begin
        mix_d = popcount(vout_q);
        if (pwm_q == PWM_LAST) begin
            pwm_d = '0;
        end else begin
            pwm_d = pwm_q + {{(VID_W-1){1'b0}}, 1'b1};
        end
        spk_d = ({1'b0, pwm_q} < mix_q);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_ready_q <= 1'b0;
            active_q    <= '0;
            vout_q      <= '0;
            mix_q       <= '0;
            pwm_q       <= '0;
            spk_q       <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                half_q[v] <= 20'd0;
                cnt_q[v]  <= 20'd0;
            end
        end else begin
            key_ready_q <= 1'b1;
            active_q    <= active_d;
            vout_q      <= vout_d;
            mix_q       <= mix_d;
            pwm_q       <= pwm_d;
            spk_q       <= spk_d;
            half_q      <= half_d;
            cnt_q       <= cnt_d;
        end
    end

    assign key_ready    = key_ready_q;
    assign voice_active = active_q;
    assign voice_out    = vout_q;
    assign mix          = mix_q;
    assign speaker      = spk_q;

endmodule

// File: tb/tb_tone_synth.sv
// Directed self-checking bench for tone_synth: hand-computed periods, mix/PWM
// behaviour, retune, invalid notes, out-of-range voices and async reset.
module tb_tone_synth;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [1:0] key_voice = 2'd0;
    logic       key_on = 1'b0;
    logic [3:0] key_note = 4'd0;
    logic [2:0] key_octave = 3'd0;
    logic       key_ready;
    logic [3:0] voice_active, voice_out;
    logic [2:0] mix;
    logic       speaker;

    logic       k3_valid = 1'b0;
    logic [1:0] k3_voice = 2'd0;
    logic       k3_ready;
    logic [2:0] act3, out3;
    logic [2:0] mix3;
    logic       spk3;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int hi_cnt;

    always #5 clk = ~clk;

    tone_synth #(.NUM_VOICES(4), .VID_W(2)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_ready(key_ready),
        .key_voice(key_voice), .key_on(key_on), .key_note(key_note), .key_octave(key_octave),
        .voice_active(voice_active), .voice_out(voice_out), .mix(mix), .speaker(speaker)
    );

    tone_synth #(.NUM_VOICES(3), .VID_W(2)) dut3 (
        .clk(clk), .reset(reset), .key_valid(k3_valid), .key_ready(k3_ready),
        .key_voice(k3_voice), .key_on(key_on), .key_note(key_note), .key_octave(key_octave),
        .voice_active(act3), .voice_out(out3), .mix(mix3), .speaker(spk3)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] v, input logic on, input logic [3:0] note, input logic [2:0] oct);
        @(negedge clk);
        key_valid  = 1'b1;
        key_voice  = v;
        key_on     = on;
        key_note   = note;
        key_octave = oct;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic send3(input logic [1:0] v, input logic on, input logic [3:0] note, input logic [2:0] oct);
        @(negedge clk);
        k3_valid   = 1'b1;
        k3_voice   = v;
        key_on     = on;
        key_note   = note;
        key_octave = oct;
        @(posedge clk);
        #1;
        k3_valid = 1'b0;
    endtask

    // Cycles after the current edge until voice_out[v] reaches lvl (budget-limited).
    task automatic wait_level(input int v, input logic lvl, input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (voice_out[v] !== lvl && n < budget);
    endtask

    initial begin
        // Reset state
        #22;
        check_eq("rst_ready", 32'(key_ready), 32'd0);
        check_eq("rst_active", 32'(voice_active), 32'd0);
        check_eq("rst_out", 32'(voice_out), 32'd0);
        check_eq("rst_mix_spk", 32'({mix, speaker}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("ready_after_rst", 32'(key_ready), 32'd1);

        // Out-of-range voice on a 3-voice instance
        send3(2'd0, 1'b1, 4'd11, 3'd7);
        check_eq("dut3_press_v0", 32'(act3), 32'd1);
        send3(2'd3, 1'b1, 4'd9, 3'd4);
        check_eq("dut3_oor_press", 32'(act3), 32'd1);
        send3(2'd3, 1'b0, 4'd0, 3'd4);
        check_eq("dut3_oor_release", 32'(act3), 32'd1);

        // A4 on voice 0
        send(2'd0, 1'b1, 4'd9, 3'd4);
        check_eq("a4_active", 32'(voice_active), 32'd1);
        check_eq("a4_out_low", 32'(voice_out), 32'd0);
        wait_level(0, 1'b1, 30000, cyc);
        check_eq("a4_first_rise", 32'(cyc), 32'd28409);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_eq("a4_mix", 32'(mix), 32'd1);
        hi_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            hi_cnt += int'(speaker);
        end
        check_eq("a4_speaker_duty", 32'(hi_cnt), 32'd2);
        send(2'd0, 1'b0, 4'd9, 3'd4);
        check_eq("a4_release", 32'({voice_active, voice_out}), 32'd0);

        // A5 and C0 on voice 1
        send(2'd1, 1'b1, 4'd9, 3'd5);
        wait_level(1, 1'b1, 20000, cyc);
        check_eq("a5_first_rise", 32'(cyc), 32'd14204);
        send(2'd1, 1'b1, 4'd0, 3'd0);
        check_eq("c0_half", 32'(dut.half_q[1]), 32'd764448);
        check_eq("c0_out_low", 32'(voice_out[1]), 32'd0);
        check_eq("c0_active", 32'(voice_active), 32'b0010);
        send(2'd1, 1'b0, 4'd0, 3'd0);

        // All four voices on B7 (half 3163)
        for (int v = 0; v < 4; v++) send(2'(v), 1'b1, 4'd11, 3'd7);
        cyc = 0;
        while (voice_out !== 4'hF && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("all_high", 32'(voice_out), 32'hF);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_eq("all_mix", 32'(mix), 32'd4);
        hi_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            hi_cnt += int'(speaker);
        end
        check_eq("all_speaker_held", 32'(hi_cnt), 32'd6);
        for (int v = 0; v < 4; v++) send(2'(v), 1'b0, 4'd11, 3'd7);
        check_eq("all_released", 32'({voice_active, voice_out}), 32'd0);
        @(posedge clk);
        #1;
        check_eq("rel_mix_zero", 32'(mix), 32'd0);
        @(posedge clk);
        #1;
        check_eq("rel_speaker_zero", 32'(speaker), 32'd0);

        // Voice 2: B7 period, then retune mid-high to B4
        send(2'd2, 1'b1, 4'd11, 3'd7);
        wait_level(2, 1'b1, 4000, cyc);
        check_eq("b7_rise", 32'(cyc), 32'd3163);
        wait_level(2, 1'b0, 4000, cyc);
        check_eq("b7_fall", 32'(cyc), 32'd3163);
        wait_level(2, 1'b1, 4000, cyc);
        repeat (10) @(posedge clk);
        send(2'd2, 1'b1, 4'd11, 3'd4);
        check_eq("retune_drop", 32'(voice_out), 32'd0);
        check_eq("retune_active", 32'(voice_active), 32'b0100);
        wait_level(2, 1'b1, 30000, cyc);
        check_eq("retune_rise", 32'(cyc), 32'd25310);
        send(2'd2, 1'b1, 4'd13, 3'd4);
        check_eq("bad_note_silences", 32'({voice_active, voice_out}), 32'd0);

        // Async reset while three voices sound
        for (int v = 0; v < 3; v++) send(2'(v), 1'b1, 4'd11, 3'd7);
        repeat (3170) @(posedge clk);
        #1;
        check_eq("three_sounding", 32'(voice_out), 32'b0111);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_rst_outs", 32'({voice_active, voice_out, mix, speaker}), 32'd0);
        check_eq("async_rst_ready", 32'(key_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("ready_after_rerst", 32'(key_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tone_synth.md
# tone_synth

Parametrised polyphonic square-wave tone generator for the FPGA piano, successor to the single fixed-pitch note divider. Holds NUM_VOICES independent voices, each tuned by a (note, octave) key command to any of 96 equal-tempered pitches. All voices are mixed into one 1-bit PWM speaker output. Sits between the key scanner/voice allocator and the speaker pin, on the 25 MHz system clock.

## Interface
- NUM_VOICES, 4: number of independent voices (1..8).
- VID_W, 2: width of the voice index; must equal ceil(log2(NUM_VOICES)), minimum 1.
- clk  input  1  system clock, 25 MHz.
- reset  input  1  asynchronous, active-high reset.
- key_valid  input  1  key command present this cycle.
- key_ready  output  1  block can accept a command.
- key_voice  input  VID_W  target voice index.
- key_on  input  1  1 = press (tune and start), 0 = release (silence).
- key_note  input  4  semitone 0=C .. 11=B; 12..15 invalid.
- key_octave  input  3  octave 0..7; 4 is the reference octave (A4 = 440 Hz).
- voice_active  output  NUM_VOICES  per-voice sounding flag.
- voice_out  output  NUM_VOICES  per-voice square wave.
- mix  output  VID_W+1  registered count of voice_out bits currently high.
- speaker  output  1  PWM-mixed audio.

One clock; reset is asynchronous and active-high.

## Operation
- Reset values: key_ready=0 while reset is high and 1 from the first edge after release; voice_active=0; voice_out=0; mix=0; speaker=0. All counters are 0.
- Command accepted on a rising edge with key_valid & key_ready. key_ready stays 1 outside reset, so every command is accepted. key_voice >= NUM_VOICES is ignored.
- Half-period table for octave 4, in cycles at 25 MHz:
  - C 47778, C# 45097, D 42566, D# 40177, E 37922, F 35793
  - F# 33784, G 31888, G# 30098, A 28409, A# 26815, B 25310
- Octave scaling:
  - half = T[note] << (4-oct) for oct<4.
  - half = T[note] >> (oct-4) for oct>4; the shift truncates.
  - The half register is 20 bits wide. The maximum, C0 = 764448, fits.
- Press with a valid note:
  - Load half into the voice.
  - Set voice_active=1, clear the voice counter, force voice_out=0.
  - This applies even if the voice is already active (retune with phase reset).
- Release, or press with note 12..15: voice_active=0, counter=0, voice_out=0.
- Active voice:
  - The counter increments every cycle.
  - When counter == half-1: counter goes to 0 and voice_out toggles.
  - Full period = 2*half cycles at 50% duty.
- mix = popcount(voice_out), registered.
- PWM:
  - pwm_cnt wraps over 0..NUM_VOICES-1.
  - speaker is registered as (pwm_cnt < mix).
  - mix=0 gives a constant 0; mix=NUM_VOICES gives a constant 1.
- Reset asserted mid-note: everything returns to the reset values immediately, without waiting for a clock.

## Timing
- Command accepted at edge E:
  - voice_active and the new half value are valid after E, with counter=0.
  - The first voice_out rise occurs after edge E+half, then toggles every half cycles.
- Release at edge E: voice_active=0 and voice_out=0 after E, even if the wave was high.
- voice_out to mix: 1 cycle. mix to speaker: 1 cycle. Total 2 cycles from voice_out to speaker.
- Only one command per cycle. Voices not addressed by a command continue undisturbed.

## Test plan
- Reset, then press voice 0 with A/oct4 (note 9, octave 4) -> voice_out[0] rises 28409 cycles after accept. It then has period 56818, matching the legacy divider. speaker duty is 1/4 with NUM_VOICES=4.
- Press voice 1 with A/oct5 and C/oct0 in turn -> half is 14204 and 764448 respectively; period is 28408 and 1528896 cycles.
- Voices 0..3 all pressed with the same note in the same-phase sequence -> mix reaches 4 and speaker is held at 1. Release all -> mix=0 and speaker=0 two cycles after release.
- Press voice 2 then, mid-high-phase, press again with note 11 oct4 -> voice_out[2] drops to 0 next cycle and rises again 25310 cycles later.
- Press with key_note=13 on an active voice, and key_voice out of range -> the first silences the voice. The second leaves all voices unchanged.
- Assert reset asynchronously between edges while 3 voices are sounding -> all outputs are 0 before the next edge. After release, key_ready=1 on the first edge.
